// File: rtl/noc_s1_axi_wr_slave_if.sv
// ----------------------------------------------------------------------------
// noc_s1_axi_wr_slave_if
// AXI3-style write-channel bundle for NoC slave port S1 (AW, W and B channels).
//   master modport : drives AW/W payload and valids, BREADY; sees the readies and B
//   slave  modport : the opposite view, used by noc_s1_axi_wr_slave
// Clock and reset are not part of the bundle; they stay plain module ports.
// ----------------------------------------------------------------------------
interface noc_s1_axi_wr_slave_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ID_W   = 8
) ();

    // AW channel
    logic [ID_W-1:0]   S1_AWID;
    logic [ADDR_W-1:0] S1_AWADDR;
    logic [3:0]        S1_AWLEN;
    logic [2:0]        S1_AWSIZE;
    logic [1:0]        S1_AWBURST;
    logic              S1_AWVALID;
    logic              S1_AWREADY;
    // W channel
    logic [DATA_W-1:0] S1_WDATA;
    logic [3:0]        S1_WSTRB;
    logic              S1_WLAST;
    logic              S1_WVALID;
    logic              S1_WREADY;
    // B channel
    logic [ID_W-1:0]   S1_BID;
    logic [1:0]        S1_BRESP;
    logic              S1_BVALID;
    logic              S1_BREADY;

    modport master (
        output S1_AWID, S1_AWADDR, S1_AWLEN, S1_AWSIZE, S1_AWBURST, S1_AWVALID,
        output S1_WDATA, S1_WSTRB, S1_WLAST, S1_WVALID,
        output S1_BREADY,
        input  S1_AWREADY, S1_WREADY, S1_BID, S1_BRESP, S1_BVALID
    );

    modport slave (
        input  S1_AWID, S1_AWADDR, S1_AWLEN, S1_AWSIZE, S1_AWBURST, S1_AWVALID,
        input  S1_WDATA, S1_WSTRB, S1_WLAST, S1_WVALID,
        input  S1_BREADY,
        output S1_AWREADY, S1_WREADY, S1_BID, S1_BRESP, S1_BVALID
    );

endinterface

// File: rtl/noc_s1_axi_wr_slave.sv
// ----------------------------------------------------------------------------
// noc_s1_axi_wr_slave
// Write-channel slave endpoint for NoC port S1. Accepts one AW at a time, stores
// its W burst into a local word memory, then returns a single B response.
// Ports:
//   ACLK       clock, rising edge
//   ASW_RESET  synchronous active-high reset (memory contents are kept)
//   s1         AW/W/B bundle, slave view
//   DBG_ADDR   back-door word index
//   DBG_RDATA  mem[DBG_ADDR], combinational
// ----------------------------------------------------------------------------
module noc_s1_axi_wr_slave #(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ID_W      = 8,
    parameter int unsigned MEM_DEPTH = 256
) (
    input  logic                         ACLK,
    input  logic                         ASW_RESET,
    noc_s1_axi_wr_slave_if.slave         s1,
    input  logic [$clog2(MEM_DEPTH)-1:0] DBG_ADDR,
    output logic [DATA_W-1:0]            DBG_RDATA
);

    localparam int unsigned IdxW     = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] MemBytes = ADDR_W'(4 * MEM_DEPTH);

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;
    localparam logic [1:0] RespDecerr = 2'b11;

    typedef enum logic [1:0] {StIdle, StData, StResp} state_e;

    state_e state_q, state_d;

    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] addr_q;
    logic [3:0]        len_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [3:0]        cnt_q;
    logic              cfg_err_q;
    logic              decerr_q;
    logic              slverr_q;
    logic [1:0]        bresp_q;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    logic              aw_hs, w_hs, b_hs;
    logic              last_beat, beat_decerr, wlast_err, cfg_err;
    logic              decerr_any, slverr_any, mem_we;
    logic [1:0]        resp_final;
    logic [ADDR_W-1:0] inc, wrap_mask, addr_nxt;

    assign aw_hs = s1.S1_AWVALID && (state_q == StIdle);
    assign w_hs  = s1.S1_WVALID  && (state_q == StData);
    assign b_hs  = s1.S1_BREADY  && (state_q == StResp);

    // Burst length is always LEN+1 beats; WLAST only feeds the error check.
    assign last_beat   = (cnt_q == len_q);
    assign beat_decerr = (addr_q >= MemBytes);
    assign wlast_err   = (s1.S1_WLAST != last_beat);

    assign cfg_err = (s1.S1_AWSIZE > 3'd2) || (s1.S1_AWBURST == 2'b11) ||
                     ((s1.S1_AWBURST == 2'b10) &&
                      !(s1.S1_AWLEN inside {4'd1, 4'd3, 4'd7, 4'd15}));

    // Flags including the beat currently being accepted, so the last beat counts.
    assign decerr_any = decerr_q | beat_decerr;
    assign slverr_any = slverr_q | wlast_err;
    assign resp_final = decerr_any ? RespDecerr : (slverr_any ? RespSlverr : RespOkay);

    assign mem_we = w_hs && !cfg_err_q && !beat_decerr && !ASW_RESET;

    // Next beat address
    always_comb begin
        inc       = ADDR_W'(1) << size_q;
        wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) * inc) - ADDR_W'(1);
        case (burst_q)
            2'b00:   addr_nxt = addr_q;
            // addr stays inside its wrap window, so its upper bits are the base
            2'b10:   addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + inc) & wrap_mask);
            default: addr_nxt = addr_q + inc;
        endcase
    end

    // FSM: state register
    always_ff @(posedge ACLK) begin
        if (ASW_RESET) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (aw_hs) state_d = StData;
            StData:  if (w_hs && last_beat) state_d = StResp;
            StResp:  if (b_hs) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs, decoded purely from flops so they change only on ACLK
    always_comb begin
        s1.S1_AWREADY = (state_q == StIdle);
        s1.S1_WREADY  = (state_q == StData);
        s1.S1_BVALID  = (state_q == StResp);
        s1.S1_BRESP   = bresp_q;
        s1.S1_BID     = id_q;
    end

    // Transaction datapath
    always_ff @(posedge ACLK) begin
        if (ASW_RESET) begin
            id_q      <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
            decerr_q  <= 1'b0;
            slverr_q  <= 1'b0;
            bresp_q   <= RespOkay;
        end else begin
            if (aw_hs) begin
                id_q      <= s1.S1_AWID;
                addr_q    <= s1.S1_AWADDR;
                len_q     <= s1.S1_AWLEN;
                size_q    <= s1.S1_AWSIZE;
                burst_q   <= s1.S1_AWBURST;
                cnt_q     <= '0;
                cfg_err_q <= cfg_err;
                decerr_q  <= 1'b0;
                slverr_q  <= cfg_err;
            end
            if (w_hs) begin
                addr_q   <= addr_nxt;
                cnt_q    <= cnt_q + 4'd1;
                decerr_q <= decerr_any;
                slverr_q <= slverr_any;
                if (last_beat) begin
                    bresp_q <= resp_final;
                end
            end
        end
    end

    // Word memory, not cleared by reset; narrow beats use WSTRB as given
    always_ff @(posedge ACLK) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (s1.S1_WSTRB[i]) begin
                    mem[addr_q[IdxW+1:2]][8*i +: 8] <= s1.S1_WDATA[8*i +: 8];
                end
            end
        end
    end

    assign DBG_RDATA = mem[DBG_ADDR];

endmodule

// File: tb/tb_noc_s1_axi_wr_slave.sv
// ----------------------------------------------------------------------------
// tb_noc_s1_axi_wr_slave
// Directed bench for noc_s1_axi_wr_slave: inputs driven and outputs sampled 1 ns
// after each rising edge; expected values are hand-computed constants.
// ----------------------------------------------------------------------------
module tb_noc_s1_axi_wr_slave;

    logic       ACLK;
    logic       ASW_RESET;
    logic [7:0] DBG_ADDR;
    logic [31:0] DBG_RDATA;

    int checks = 0;
    int errors = 0;

    noc_s1_axi_wr_slave_if #(.ADDR_W(32), .DATA_W(32), .ID_W(8)) s1 ();

    noc_s1_axi_wr_slave #(
        .ADDR_W   (32),
        .DATA_W   (32),
        .ID_W     (8),
        .MEM_DEPTH(256)
    ) dut (
        .ACLK     (ACLK),
        .ASW_RESET(ASW_RESET),
        .s1       (s1),
        .DBG_ADDR (DBG_ADDR),
        .DBG_RDATA(DBG_RDATA)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic rd(input string tag, input logic [7:0] idx, input logic [31:0] exp);
        DBG_ADDR = idx;
        #1;
        check(tag, DBG_RDATA, exp);
    endtask

    // AW handshake, then WREADY must be up the very next cycle
    task automatic aw(input logic [7:0] id, input logic [31:0] addr, input logic [3:0] len,
                      input logic [2:0] size, input logic [1:0] burst);
        int n;
        s1.S1_AWID    = id;
        s1.S1_AWADDR  = addr;
        s1.S1_AWLEN   = len;
        s1.S1_AWSIZE  = size;
        s1.S1_AWBURST = burst;
        s1.S1_AWVALID = 1'b1;
        n = 0;
        while (!s1.S1_AWREADY && n < 20) begin
            step();
            n++;
        end
        check("aw_ready_wait", 32'(s1.S1_AWREADY), 32'd1);
        step();
        s1.S1_AWVALID = 1'b0;
        check("aw_wready_next", 32'(s1.S1_WREADY), 32'd1);
        check("aw_awready_drop", 32'(s1.S1_AWREADY), 32'd0);
    endtask

    task automatic w_beat(input logic [31:0] data, input logic [3:0] strb, input logic last);
        int n;
        s1.S1_WDATA  = data;
        s1.S1_WSTRB  = strb;
        s1.S1_WLAST  = last;
        s1.S1_WVALID = 1'b1;
        n = 0;
        while (!s1.S1_WREADY && n < 20) begin
            step();
            n++;
        end
        check("w_ready_wait", 32'(s1.S1_WREADY), 32'd1);
        step();
        s1.S1_WVALID = 1'b0;
    endtask

    // Called in the cycle right after the final beat, with BREADY=1
    task automatic finish_b(input string tag, input logic [1:0] resp, input logic [7:0] id);
        check({tag, "_bvalid"}, 32'(s1.S1_BVALID), 32'd1);
        check({tag, "_bresp"}, 32'(s1.S1_BRESP), 32'(resp));
        check({tag, "_bid"}, 32'(s1.S1_BID), 32'(id));
        check({tag, "_wready0"}, 32'(s1.S1_WREADY), 32'd0);
        step();
        check({tag, "_bvalid_drop"}, 32'(s1.S1_BVALID), 32'd0);
        check({tag, "_awready_back"}, 32'(s1.S1_AWREADY), 32'd1);
    endtask

    initial begin
        ASW_RESET     = 1'b1;
        DBG_ADDR      = '0;
        s1.S1_AWID    = '0;
        s1.S1_AWADDR  = '0;
        s1.S1_AWLEN   = '0;
        s1.S1_AWSIZE  = '0;
        s1.S1_AWBURST = '0;
        s1.S1_AWVALID = 1'b0;
        s1.S1_WDATA   = '0;
        s1.S1_WSTRB   = '0;
        s1.S1_WLAST   = 1'b0;
        s1.S1_WVALID  = 1'b0;
        s1.S1_BREADY  = 1'b1;

        // Reset state
        step();
        step();
        ASW_RESET = 1'b0;
        check("rst_awready", 32'(s1.S1_AWREADY), 32'd1);
        check("rst_wready", 32'(s1.S1_WREADY), 32'd0);
        check("rst_bvalid", 32'(s1.S1_BVALID), 32'd0);
        check("rst_bresp", 32'(s1.S1_BRESP), 32'd0);
        check("rst_bid", 32'(s1.S1_BID), 32'd0);

        // INCR 0x10, 4 beats -> mem[4..7]
        aw(8'h5A, 32'h10, 4'd3, 3'd2, 2'b01);
        w_beat(32'd1, 4'hF, 1'b0);
        w_beat(32'd2, 4'hF, 1'b0);
        w_beat(32'd3, 4'hF, 1'b0);
        check("incr_bvalid_early", 32'(s1.S1_BVALID), 32'd0);
        w_beat(32'd4, 4'hF, 1'b1);
        finish_b("incr", 2'b00, 8'h5A);
        rd("incr_m4", 8'd4, 32'd1);
        rd("incr_m5", 8'd5, 32'd2);
        rd("incr_m6", 8'd6, 32'd3);
        rd("incr_m7", 8'd7, 32'd4);

        // WRAP 0x38, 4 beats: 0x38,0x3C,0x30,0x34
        aw(8'h21, 32'h38, 4'd3, 3'd2, 2'b10);
        w_beat(32'hA, 4'hF, 1'b0);
        w_beat(32'hB, 4'hF, 1'b0);
        w_beat(32'hC, 4'hF, 1'b0);
        w_beat(32'hD, 4'hF, 1'b1);
        finish_b("wrap", 2'b00, 8'h21);
        rd("wrap_m14", 8'd14, 32'hA);
        rd("wrap_m15", 8'd15, 32'hB);
        rd("wrap_m12", 8'd12, 32'hC);
        rd("wrap_m13", 8'd13, 32'hD);

        // Seed mem[0..1] so dropped out-of-range beats would be visible if they aliased
        aw(8'h01, 32'h0, 4'd1, 3'd2, 2'b01);
        w_beat(32'h11, 4'hF, 1'b0);
        w_beat(32'h22, 4'hF, 1'b1);
        finish_b("seed", 2'b00, 8'h01);

        // INCR 0x3F8 crosses the end of memory -> DECERR
        aw(8'h03, 32'h3F8, 4'd3, 3'd2, 2'b01);
        w_beat(32'h31, 4'hF, 1'b0);
        w_beat(32'h32, 4'hF, 1'b0);
        w_beat(32'h33, 4'hF, 1'b0);
        w_beat(32'h34, 4'hF, 1'b1);
        finish_b("decerr", 2'b11, 8'h03);
        rd("decerr_m254", 8'd254, 32'h31);
        rd("decerr_m255", 8'd255, 32'h32);
        rd("decerr_m0", 8'd0, 32'h11);
        rd("decerr_m1", 8'd1, 32'h22);

        // Early WLAST on beat 2: still 4 beats, data written, SLVERR
        aw(8'h04, 32'h80, 4'd3, 3'd2, 2'b01);
        w_beat(32'hC1, 4'hF, 1'b0);
        w_beat(32'hC2, 4'hF, 1'b1);
        w_beat(32'hC3, 4'hF, 1'b0);
        check("wlast_still_wready", 32'(s1.S1_WREADY), 32'd1);
        w_beat(32'hC4, 4'hF, 1'b0);
        finish_b("wlast", 2'b10, 8'h04);
        rd("wlast_m32", 8'd32, 32'hC1);
        rd("wlast_m35", 8'd35, 32'hC4);

        // Reserved burst type: no write, SLVERR
        aw(8'h05, 32'h10, 4'd0, 3'd2, 2'b11);
        w_beat(32'hDEAD, 4'hF, 1'b1);
        finish_b("rsvd", 2'b10, 8'h05);
        rd("rsvd_m4", 8'd4, 32'd1);

        // BREADY stall for 5 cycles with a competing AW
        s1.S1_BREADY = 1'b0;
        aw(8'h33, 32'h40, 4'd0, 3'd2, 2'b01);
        w_beat(32'h1234_5678, 4'hF, 1'b1);
        s1.S1_AWID    = 8'h99;
        s1.S1_AWADDR  = 32'h44;
        s1.S1_AWVALID = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_bvalid", 32'(s1.S1_BVALID), 32'd1);
            check("stall_bresp", 32'(s1.S1_BRESP), 32'd0);
            check("stall_bid", 32'(s1.S1_BID), 32'h33);
            check("stall_awready", 32'(s1.S1_AWREADY), 32'd0);
            step();
        end
        s1.S1_AWVALID = 1'b0;
        s1.S1_BREADY  = 1'b1;
        step();
        check("stall_bvalid_drop", 32'(s1.S1_BVALID), 32'd0);
        check("stall_awready_back", 32'(s1.S1_AWREADY), 32'd1);
        check("stall_aw_ignored", 32'(s1.S1_WREADY), 32'd0);
        rd("stall_m16", 8'd16, 32'h1234_5678);

        // Narrow beat, lanes 0 and 2 only
        aw(8'h44, 32'h40, 4'd0, 3'd0, 2'b01);
        w_beat(32'hFFFF_FFFF, 4'b0101, 1'b1);
        finish_b("strb", 2'b00, 8'h44);
        rd("strb_m16", 8'd16, 32'h12FF_56FF);

        // Reset after beat 2 of a 4-beat burst
        aw(8'h07, 32'hC0, 4'd3, 3'd2, 2'b01);
        w_beat(32'hB1, 4'hF, 1'b0);
        w_beat(32'hB2, 4'hF, 1'b0);
        ASW_RESET = 1'b1;
        step();
        ASW_RESET = 1'b0;
        check("mrst_awready", 32'(s1.S1_AWREADY), 32'd1);
        check("mrst_wready", 32'(s1.S1_WREADY), 32'd0);
        check("mrst_bvalid", 32'(s1.S1_BVALID), 32'd0);
        check("mrst_bid", 32'(s1.S1_BID), 32'd0);
        rd("mrst_m48", 8'd48, 32'hB1);
        rd("mrst_m49", 8'd49, 32'hB2);

        // Normal operation resumes
        aw(8'h08, 32'hD0, 4'd0, 3'd2, 2'b01);
        w_beat(32'hE1, 4'hF, 1'b1);
        finish_b("post", 2'b00, 8'h08);
        rd("post_m52", 8'd52, 32'hE1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
